magnitude_uart_tx: RTL and testbench
====================================

Name: magnitude_uart_tx

Overview:
- Consumer end of the Magnitude output stream from the DFT datapath.
- Accepts 32-bit magnitude words through a valid/ready handshake and buffers them in a small FIFO.
- Serializes each word onto a UART 8N1 line as 4 bytes, most significant byte first, so spectrum bins can leave the FPGA for a host.
- Sits between Main_Module's Magnitude output and the board TX pin.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 8: word entries in the input FIFO; power of 2, >= 2.
- ADDR_W, 3: log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous reset, active-high.
- mag_data  input  32  magnitude word from the DFT.
- mag_valid  input  1  mag_data valid this cycle.
- mag_ready  output  1  FIFO can accept a word this cycle.
- tx  output  1  UART serial line, idle high.
- busy  output  1  serializer is mid-word (any state other than IDLE).
- fifo_count  output  ADDR_W+1  words currently buffered, 0..FIFO_DEPTH.

Behaviour:
- Clocking: one clock domain (clk). rst is asynchronous and active-high. All state clears immediately on rst assertion, and the block runs from the first clk edge after deassertion.
- Reset values: tx=1, busy=0, fifo_count=0, FIFO pointers=0, FSM=IDLE, bit/baud counters=0. mag_ready is forced 0 while rst is high and is 1 after release (FIFO empty).
- Handshake: push occurs on a clk edge with mag_valid && mag_ready. mag_ready = !full && !rst (combinational from registered count). mag_data must be held by the source until accepted. There is no data loss path.
- FIFO:
  - Circular buffer with wrap-around pointers; fifo_count is registered.
  - Simultaneous push and pop leaves the count unchanged.
  - Full: mag_ready=0 and no push. A pop frees a slot, so ready rises on the next cycle.
  - Empty: no pop occurs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count>0, pop the head word into a 32-bit shift register, set byte_idx=0, and go to START on the next edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send the current byte LSB first, each bit for CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte_idx<3, increment byte_idx, shift the word left by 8, and go to START. Otherwise go to IDLE.
- Byte order: bits[31:24], [23:16], [15:8], [7:0].
- Timing:
  - Bytes within one word are back-to-back with no extra idle between stop and start.
  - Exactly one IDLE clk (tx=1) between words.
  - One word = 40*CLKS_PER_BIT + 1 cycles.
  - First start bit begins 2 clk edges after the push of a word into an empty idle block (push edge, pop edge).
- Counters: baud counter counts 0..CLKS_PER_BIT-1 and wraps. The bit counter is 3 bits. No arithmetic overflow is possible at legal parameters.
- Output register: tx is driven from a register with no combinational glitch path.
- Reset mid-frame: tx returns high immediately (async). The partial byte is abandoned, the FIFO is flushed, and no bits are resent after release.
- busy=1 from the START entry of a word's first byte through the last clk of its final stop bit.

Test Plan:
- With CLKS_PER_BIT=4, push 32'hA5C3_0F81 into an idle block:
  - tx emits bytes A5, C3, 0F, 81, each as start(0), LSB-first data, stop(1), 40 bits at 4 clk/bit.
  - Sampling mid-bit reconstructs the word.
  - busy high for 160 cycles.
- Push 9 consecutive words 0x0000_0001..0x0000_0009 with mag_valid held high:
  - First 8 accepted back-to-back. fifo_count reaches 8 when the first pop has not yet occurred, else 7.
  - mag_ready drops at full and rises the cycle after a pop.
  - All 9 words appear on tx in order; no word is lost or duplicated.
- Back-to-back words 0xFFFF_FFFF then 0x0000_0000:
  - Exactly one clk of tx=1 between word 1's final stop bit and word 2's start bit.
  - No gaps between bytes within a word.
- Assert rst at clk 50 mid-transmission with 3 words queued:
  - tx=1 and fifo_count=0 the same cycle; mag_ready=0 while rst is high.
  - After release, tx stays high with no further output until a new push.
- Push and pop in the same edge with fifo_count=3: fifo_count stays 3, and the head pointer wraps correctly after 8+ total pushes.
- mag_valid pulses while mag_ready=0 (FIFO full): those words are not captured, and the transmitted sequence matches only handshaked words.

Source files
------------

// File: rtl/magnitude_uart_tx.sv
// Buffers 32-bit magnitude words in a small FIFO and sends each one over a UART 8N1 line
// as four bytes, most significant byte first, LSB first within each byte.
module magnitude_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mag_data,
    input  logic              mag_valid,
    output logic              mag_ready,
    output logic              tx,
    output logic              busy,
    output logic [ADDR_W:0]   fifo_count
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [1:0]          byte_q, byte_d;
    logic [31:0]         shreg_q, shreg_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [31:0]         mem_q [FIFO_DEPTH];

    logic                push_s;
    logic                pop_s;
    logic                full_s;
    logic                baud_done_s;
    logic [31:0]         head_s;

    assign full_s      = (count_q == COUNT_FULL);
    assign mag_ready   = !full_s && !rst;
    assign push_s      = mag_valid && mag_ready;
    assign baud_done_s = (baud_q == BAUD_LAST);
    assign head_s      = mem_q[rd_ptr_q];

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

    // FIFO storage; contents need no reset because the pointers and count gate every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= mag_data;
        end
    end

    // FIFO pointer and occupancy next-state; pointers wrap naturally at the power-of-2 depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Serializer FSM next-state; tx and busy are computed from the next state so both leave flops
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        pop_s   = 1'b0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop_s   = 1'b1;
                    shreg_d = head_s;
                    byte_d  = 2'd0;
                    bit_d   = 3'd0;
                    baud_d  = '0;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_done_s) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done_s) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done_s) begin
                    baud_d = '0;
                    // Next byte follows immediately; after the last byte spend one cycle in IDLE
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        shreg_d = {shreg_q[23:0], 8'h00};
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[5'd24 + {2'b00, bit_d}];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State registers; reset abandons any frame in flight and flushes the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            byte_q   <= 2'd0;
            shreg_q  <= 32'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_magnitude_uart_tx.sv
// Directed and randomized bench for magnitude_uart_tx: a UART receiver decodes tx into words
// which are compared against the queue of words that completed the valid/ready handshake.
module tb_magnitude_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk;
    logic          rst;
    logic [31:0]   mag_data;
    logic          mag_valid;
    logic          mag_ready;
    logic          tx;
    logic          busy;
    logic [AW:0]   fifo_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];
    logic [31:0] rx_words [$];

    magnitude_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .ADDR_W       (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mag_data   (mag_data),
        .mag_valid  (mag_valid),
        .mag_ready  (mag_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART receiver: samples each bit in its middle, checks framing and intra-word byte spacing
    initial begin : rx_mon
        int     cyc;
        int     rx_cnt;
        int     k;
        int     rx_bcnt;
        int     last_start;
        bit     rx_act;
        logic [7:0]  rx_byte;
        logic [31:0] rx_word;
        cyc = 0; rx_cnt = 0; rx_bcnt = 0; last_start = 0; rx_act = 1'b0;
        rx_byte = 8'h00; rx_word = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                rx_act  = 1'b0;
                rx_bcnt = 0;
            end else if (!rx_act) begin
                if (tx === 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                    if (rx_bcnt != 0) chk("byte_gap", 32'(cyc - last_start), 32'(10 * CPB));
                    last_start = cyc;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % CPB == CPB / 2) begin
                    k = rx_cnt / CPB;
                    if (k == 0)      chk("start_bit", {31'd0, tx}, 32'd0);
                    else if (k <= 8) rx_byte[k-1] = tx;
                    else             chk("stop_bit", {31'd0, tx}, 32'd1);
                end
                if (rx_cnt == 10 * CPB - 1) begin
                    rx_act  = 1'b0;
                    rx_word = {rx_word[23:0], rx_byte};
                    rx_bcnt++;
                    if (rx_bcnt == 4) begin
                        rx_words.push_back(rx_word);
                        rx_bcnt = 0;
                    end
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that accepted the word
    task automatic push(input logic [31:0] w, input bit hold, output int waited);
        int n;
        n = 0;
        mag_data  = w;
        mag_valid = 1'b1;
        @(negedge clk);
        while (!mag_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("push_wait_bound", 32'(n < 2000), 32'd1);
        @(posedge clk);
        #1;
        exp_q.push_back(w);
        if (!hold) mag_valid = 1'b0;
        waited = n;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(busy === 1'b0 && fifo_count === '0) && n < 4000) begin
            n++;
            @(negedge clk);
        end
        chk("idle_wait_bound", 32'(n < 4000), 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic compare_all(input string tag);
        wait_idle();
        chk({tag, "_word_count"}, 32'(rx_words.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_words.size()) chk(tag, rx_words[i], exp_q[i]);
        end
        rx_words.delete();
        exp_q.delete();
    endtask

    task automatic wait_busy_fall(output int n);
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("busy_fall_bound", 32'(n < 400), 32'd1);
    endtask

    initial begin : stim
        int w;
        int wsum;
        int n;
        int lows;
        rst = 1'b1; mag_valid = 1'b0; mag_data = 32'h0;

        // Reset state
        #3;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", {31'd0, mag_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, mag_ready}, 32'd1);
        @(posedge clk); #1;

        // Single word into an idle block: latency and busy length
        push(32'hA5C3_0F81, 1'b0, w);
        @(negedge clk);
        chk("push_edge_count", 32'(fifo_count), 32'd1);
        chk("push_edge_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        chk("first_start_tx", {31'd0, tx}, 32'd0);
        chk("first_start_busy", {31'd0, busy}, 32'd1);
        chk("pop_count", 32'(fifo_count), 32'd0);
        n = 1;
        @(negedge clk);
        while (busy === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(n), 32'(40 * CPB));
        compare_all("word_a5c3");

        // Nine words with valid held, then pulses of valid while full
        wsum = 0;
        for (int i = 1; i <= 8; i++) begin
            push(32'(i), 1'b1, w);
            wsum += w;
        end
        chk("eight_back_to_back", 32'(wsum), 32'd0);
        mag_data = 32'd9;
        @(negedge clk);
        chk("count_after_8", 32'(fifo_count), 32'd7);
        chk("ready_after_8", {31'd0, mag_ready}, 32'd1);
        @(posedge clk); #1;
        exp_q.push_back(32'd9);
        mag_valid = 1'b0;
        mag_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("count_full", 32'(fifo_count), 32'd8);
        chk("ready_full", {31'd0, mag_ready}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            mag_valid = ~mag_valid;
            @(negedge clk);
            chk("ready_held_low", {31'd0, mag_ready}, 32'd0);
        end
        @(posedge clk); #1;
        mag_valid = 1'b0;
        @(negedge clk);
        chk("count_after_pulses", 32'(fifo_count), 32'd8);
        n = 0;
        while (!mag_ready && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("ready_rise_bound", 32'(n < 400), 32'd1);
        chk("ready_rise_tx_start", {31'd0, tx}, 32'd0);
        chk("ready_rise_count", 32'(fifo_count), 32'd7);
        @(posedge clk); #1;
        compare_all("nine_words");

        // Back-to-back words: exactly one idle clock between them
        push(32'hFFFF_FFFF, 1'b1, w);
        push(32'h0000_0000, 1'b0, w);
        wait_busy_fall(n);
        chk("gap_idle_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        chk("gap_next_busy", {31'd0, busy}, 32'd1);
        chk("gap_next_tx", {31'd0, tx}, 32'd0);
        @(posedge clk); #1;
        compare_all("ff_then_00");

        // Asynchronous reset mid-frame with three words queued
        for (int i = 0; i < 4; i++) push($urandom, (i != 3), w);
        @(negedge clk);
        chk("queued_three", 32'(fifo_count), 32'd3);
        repeat (45) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_tx", {31'd0, tx}, 32'd1);
        chk("async_rst_count", 32'(fifo_count), 32'd0);
        chk("async_rst_ready", {31'd0, mag_ready}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_ready", {31'd0, mag_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("post_rst_quiet", 32'(lows), 32'd0);
        chk("post_rst_no_words", 32'(rx_words.size()), 32'd0);
        chk("post_rst_count", 32'(fifo_count), 32'd0);
        @(posedge clk); #1;
        push($urandom, 1'b0, w);
        compare_all("after_reset");

        // Simultaneous push and pop with three words buffered
        for (int i = 0; i < 4; i++) push($urandom, (i != 3), w);
        wait_busy_fall(n);
        chk("pp_before_count", 32'(fifo_count), 32'd3);
        mag_data  = $urandom;
        mag_valid = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(mag_data);
        mag_valid = 1'b0;
        @(negedge clk);
        chk("pp_after_count", 32'(fifo_count), 32'd3);
        chk("pp_after_tx", {31'd0, tx}, 32'd0);
        @(posedge clk); #1;
        compare_all("push_pop");

        // Random words with random gaps between valid assertions
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            push($urandom, 1'b0, w);
        end
        compare_all("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
